line_buffer_ctrl: RTL and testbench

- Sequencer for the rotating (KER_SIZE+1)-bank row-buffer SRAM array used by the convolution layers.
- Accepts a raster pixel stream through a valid/ready handshake and writes each image row into the next bank in rotation.
- Once KER_SIZE rows are resident, it reads the other KER_SIZE banks at the same column while writing. This produces one KER_SIZE-tall window column per cycle for the downstream MAC array.
- After the last row it runs a flush row, so every window row of the image is emitted.

---
 rtl/lb_pkg.sv | 28 ++
 rtl/line_buffer_ctrl_wrap_counter.sv | 29 ++
 rtl/line_buffer_ctrl.sv | 163 ++++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// Shared types and helpers for the rotating row-buffer sequencer.
package lb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        FLUSH,
        DONE
    } lb_state_t;

    // Widest bank vector the helpers produce; callers keep the low KER_SIZE+1 bits.
    localparam int MAX_BANKS = 16;

    // One-hot select for bank idx.
    function automatic logic [MAX_BANKS-1:0] onehot_bank(input int unsigned idx);
        logic [MAX_BANKS-1:0] one;
        one = MAX_BANKS'(1);
        return one << idx;
    endfunction

    // Successor of bank idx in a ring of ker_size+1 banks.
    function automatic int unsigned next_bank(input int unsigned idx,
                                              input int unsigned ker_size);
        return (idx >= ker_size) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/line_buffer_ctrl_wrap_counter.sv
// Modulo counter with synchronous clear; wrap flags the enabled terminal count.
module wrap_counter #(
    parameter int MOD = 4,
    parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign wrap = en && (value == LAST);

    // Count on enable, return to zero after the last value or on clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= wrap ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Row-buffer sequencer: writes each image row into the next bank and reads
// the other banks at the same column to form one window column per issue.
module line_buffer_ctrl
    import lb_pkg::*;
#(
    parameter int KER_SIZE = 3,
    parameter int DW       = 32,
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    parameter int AW       = $clog2(IMG_W),
    parameter int RW       = $clog2(IMG_H + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    output logic [AW-1:0]       sram_a,
    output logic [KER_SIZE:0]   sram_wen,
    output logic [KER_SIZE:0]   sram_ren,
    output logic [DW-1:0]       sram_d,
    output logic                col_valid,
    output logic [AW-1:0]       col_x,
    output logic [RW-1:0]       col_y,
    output logic                busy,
    output logic                done
);

    localparam int NB = KER_SIZE + 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [RW-1:0] FILL_LAST_ROW   = RW'(KER_SIZE - 1);
    localparam logic [RW-1:0] STREAM_LAST_ROW = RW'(IMG_H - 1);
    localparam logic [RW-1:0] KER_ROWS        = RW'(KER_SIZE);

    lb_state_t state, state_nxt;

    logic [AW-1:0]        x;
    logic [RW-1:0]        r;
    logic [BW-1:0]        bank;
    logic                 x_wrap;
    logic                 clr;
    logic                 fire;
    logic                 issue;
    logic                 rd_issue;
    logic [MAX_BANKS-1:0] oh_full;
    logic [NB-1:0]        bank_oh;
    logic                 unused_r_wrap;
    logic                 unused_bank_wrap;
    logic                 unused_oh_hi;

    assign in_ready = (state == FILL) || (state == STREAM);
    assign fire     = in_valid && in_ready;
    // The flush row issues every cycle so the last window rows drain without input.
    assign issue    = fire || (state == FLUSH);
    assign rd_issue = issue && ((state == STREAM) || (state == FLUSH));
    assign clr      = (state == IDLE) && start;
    assign busy     = (state != IDLE);
    assign sram_a   = x;

    assign oh_full      = onehot_bank(32'(bank));
    assign bank_oh      = oh_full[NB-1:0];
    assign unused_oh_hi = |oh_full[MAX_BANKS-1:NB];

    wrap_counter #(.MOD(IMG_W), .W(AW)) u_x_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .en    (issue),
        .value (x),
        .wrap  (x_wrap)
    );

    wrap_counter #(.MOD(IMG_H + 1), .W(RW)) u_r_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .en    (x_wrap),
        .value (r),
        .wrap  (unused_r_wrap)
    );

    wrap_counter #(.MOD(NB), .W(BW)) u_bank_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .en    (x_wrap),
        .value (bank),
        .wrap  (unused_bank_wrap)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and SRAM issue; the flush row writes zeros into the free bank.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        sram_wen  = '0;
        sram_ren  = '0;
        sram_d    = '0;
        if (issue) begin
            sram_wen = bank_oh;
        end
        if (rd_issue) begin
            sram_ren = ~bank_oh;
        end
        if (fire) begin
            sram_d = in_data;
        end
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (x_wrap && (r == FILL_LAST_ROW)) begin
                    state_nxt = (IMG_H == KER_SIZE) ? FLUSH : STREAM;
                end
            end
            STREAM: begin
                if (x_wrap && (r == STREAM_LAST_ROW)) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (x_wrap) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Window column tag, aligned with the array's registered read data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_valid <= 1'b0;
            col_x     <= '0;
            col_y     <= '0;
        end else begin
            col_valid <= rd_issue;
            if (rd_issue) begin
                col_x <= x;
                col_y <= r - KER_ROWS;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with a small bank memory model.
module tb_line_buffer_ctrl;

    localparam int KER_SIZE = 3;
    localparam int DW       = 32;
    localparam int IMG_W    = 4;
    localparam int IMG_H    = 5;
    localparam int AW       = 2;
    localparam int RW       = 3;
    localparam int NB       = KER_SIZE + 1;
    localparam int ISSUES   = IMG_W * (IMG_H + 1);
    localparam int COLS     = IMG_W * (IMG_H - KER_SIZE + 1);

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [AW-1:0] sram_a;
    logic [NB-1:0] sram_wen;
    logic [NB-1:0] sram_ren;
    logic [DW-1:0] sram_d;
    logic          col_valid;
    logic [AW-1:0] col_x;
    logic [RW-1:0] col_y;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] mem [NB][IMG_W];

    line_buffer_ctrl #(
        .KER_SIZE (KER_SIZE),
        .DW       (DW),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sram_a    (sram_a),
        .sram_wen  (sram_wen),
        .sram_ren  (sram_ren),
        .sram_d    (sram_d),
        .col_valid (col_valid),
        .col_x     (col_x),
        .col_y     (col_y),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Bank array model: each bank captures write data on its enable.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (sram_wen[b]) mem[b][sram_a] <= sram_d;
        end
    end

    task automatic test_reset();
        logic [63:0] outs;
        rstn = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5_A5A5;
        #1;
        outs = {32'(sram_d), 1'(in_ready), 4'(sram_wen), 4'(sram_ren), 1'(col_valid),
                1'(busy), 1'(done), 2'(sram_a), 2'(col_x), 3'(col_y), 13'd0};
        n_checks++;
        if (outs !== 64'd0) $display("[TB] FAIL reset_outputs: got %h want 0", outs);
        else n_pass++;
        @(negedge clk); rstn = 1'b1; in_valid = 1'b0;
        #1;
        n_checks++;
        if ({busy, in_ready} !== 2'b00) $display("[TB] FAIL reset_idle: busy/ready got %b want 00", {busy, in_ready});
        else n_pass++;
    endtask

    task automatic test_reset_mid_fill();
        logic [63:0] outs;
        logic [3:0]  exp_wen;
        @(negedge clk); start = 1'b1; in_valid = 1'b0;
        @(negedge clk); start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            in_data = 32'(50 + i);
            #1;
            exp_wen = (i < 4) ? 4'b0001 : 4'b0010;
            n_checks++;
            if ({sram_wen, sram_a} !== {exp_wen, 2'(i % 4)})
                $display("[TB] FAIL midfill_write i=%0d: wen/a got %b/%0d want %b/%0d", i, sram_wen, sram_a, exp_wen, i % 4);
            else n_pass++;
        end
        @(negedge clk); rstn = 1'b0;
        #1;
        outs = {32'(sram_d), 1'(in_ready), 4'(sram_wen), 4'(sram_ren), 1'(col_valid),
                1'(busy), 1'(done), 2'(sram_a), 2'(col_x), 3'(col_y), 13'd0};
        n_checks++;
        if (outs !== 64'd0) $display("[TB] FAIL midfill_reset: got %h want 0", outs);
        else n_pass++;
        @(negedge clk); @(negedge clk);
        rstn = 1'b1; in_valid = 1'b0;
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00) $display("[TB] FAIL midfill_idle: busy/done got %b want 00", {busy, done});
        else n_pass++;
    endtask

    // One full frame: start pulse (with in_valid high), 24 issues, done cycle.
    task automatic run_frame(input int base, input int stall_at, input int stall_len,
                             input bit poke_start, input string tag);
        int k, cyc, stall_left, n_col, row, x, bk, prev_x, prev_y, rr, bb;
        bit stalled, prev_rd;
        logic [3:0] exp_wen, exp_ren;
        logic [DW-1:0] exp_d;
        k = 0; cyc = 0; n_col = 0; stall_left = stall_len; prev_rd = 0; prev_x = 0; prev_y = 0;
        @(negedge clk); start = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if ({in_ready, sram_wen, busy} !== 6'b0) $display("[TB] FAIL %s idle_start: ready/wen/busy got %b want 0", tag, {in_ready, sram_wen, busy});
        else n_pass++;
        while (k < ISSUES && cyc < 200) begin
            @(negedge clk);
            start    = poke_start && (cyc % 5 == 2);
            stalled  = (k == stall_at) && (stall_left > 0);
            if (stalled) stall_left--;
            in_valid = !stalled;
            in_data  = DW'(base + k);
            #1;
            row = k / IMG_W; x = k % IMG_W; bk = row % NB;
            exp_wen = stalled ? 4'b0 : 4'(1 << bk);
            exp_ren = (stalled || row < KER_SIZE) ? 4'b0 : ~(4'(1 << bk));
            exp_d   = (k >= IMG_W * IMG_H) ? '0 : DW'(base + k);
            n_checks++;
            if (in_ready !== (k < IMG_W * IMG_H)) $display("[TB] FAIL %s ready k=%0d: got %b want %b", tag, k, in_ready, k < IMG_W * IMG_H);
            else n_pass++;
            n_checks++;
            if (sram_wen !== exp_wen) $display("[TB] FAIL %s wen k=%0d: got %b want %b", tag, k, sram_wen, exp_wen);
            else n_pass++;
            n_checks++;
            if (sram_ren !== exp_ren) $display("[TB] FAIL %s ren k=%0d: got %b want %b", tag, k, sram_ren, exp_ren);
            else n_pass++;
            if (!stalled) begin
                n_checks++;
                if (sram_a !== AW'(x)) $display("[TB] FAIL %s addr k=%0d: got %0d want %0d", tag, k, sram_a, x);
                else n_pass++;
                n_checks++;
                if (sram_d !== exp_d) $display("[TB] FAIL %s wdata k=%0d: got %0d want %0d", tag, k, sram_d, exp_d);
                else n_pass++;
            end
            n_checks++;
            if ({busy, done} !== 2'b10) $display("[TB] FAIL %s busy_done k=%0d: got %b want 10", tag, k, {busy, done});
            else n_pass++;
            n_checks++;
            if (col_valid !== prev_rd) $display("[TB] FAIL %s col_valid k=%0d: got %b want %b", tag, k, col_valid, prev_rd);
            else n_pass++;
            if (prev_rd) begin
                n_checks++;
                if ({col_x, col_y} !== {AW'(prev_x), RW'(prev_y)})
                    $display("[TB] FAIL %s col_xy k=%0d: got %0d,%0d want %0d,%0d", tag, k, col_x, col_y, prev_x, prev_y);
                else n_pass++;
            end
            if (col_valid) n_col++;
            if (!stalled && row >= KER_SIZE) begin
                for (int j = 0; j < KER_SIZE; j++) begin
                    rr = row - KER_SIZE + j; bb = rr % NB;
                    n_checks++;
                    if (mem[bb][x] !== DW'(base + rr * IMG_W + x))
                        $display("[TB] FAIL %s window k=%0d row=%0d: got %0d want %0d", tag, k, rr, mem[bb][x], base + rr * IMG_W + x);
                    else n_pass++;
                end
            end
            prev_rd = !stalled && (row >= KER_SIZE);
            if (!stalled) begin
                prev_x = x; prev_y = row - KER_SIZE; k++;
            end
            cyc++;
        end
        n_checks++;
        if (k != ISSUES) $display("[TB] FAIL %s timeout: issues got %0d want %0d", tag, k, ISSUES);
        else n_pass++;
        @(negedge clk); start = 1'b0; in_valid = 1'b0;
        #1;
        if (col_valid) n_col++;
        n_checks++;
        if ({done, busy, col_valid, col_x, col_y} !== {3'b111, AW'(prev_x), RW'(prev_y)})
            $display("[TB] FAIL %s done_cycle: done/busy/cv/x/y got %b%b%b/%0d/%0d want 111/%0d/%0d", tag, done, busy, col_valid, col_x, col_y, prev_x, prev_y);
        else n_pass++;
        n_checks++;
        if (n_col != COLS) $display("[TB] FAIL %s col_count: got %0d want %0d", tag, n_col, COLS);
        else n_pass++;
    endtask

    task automatic test_idle_after_done(input string tag);
        @(negedge clk);
        #1;
        n_checks++;
        if ({done, busy, col_valid, in_ready} !== 4'b0) $display("[TB] FAIL %s after_done: done/busy/cv/ready got %b want 0000", tag, {done, busy, col_valid, in_ready});
        else n_pass++;
    endtask

    task automatic test_full_frame();
        run_frame(0, -1, 0, 1'b0, "full");
        test_idle_after_done("full");
    endtask

    task automatic test_input_stall();
        run_frame(200, 14, 3, 1'b0, "stall");
        test_idle_after_done("stall");
    endtask

    task automatic test_start_while_busy();
        run_frame(400, -1, 0, 1'b1, "startbusy");
        test_idle_after_done("startbusy");
    endtask

    task automatic test_back_to_back();
        run_frame(600, -1, 0, 1'b0, "b2b_first");
        run_frame(800, -1, 0, 1'b0, "b2b_second");
        test_idle_after_done("b2b");
    endtask

    initial begin
        test_reset();
        test_reset_mid_fill();
        test_full_frame();
        test_input_stall();
        test_start_while_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
